// File: rtl/rtc_mux_bus_ctrl.sv
// rtc_mux_bus_ctrl: bus master for the multiplexed address/data RTC interface.
// A one-cycle start runs a timed address phase on the shared bus. For reads
// and writes, a data phase follows. A bus-idle recovery gap ends every
// transaction.
//
// Ports:
//   clk      system clock, rising edge
//   reset    synchronous active-low reset
//   start    one-cycle command request, taken only while busy=0
//   op       00=write, 01=read, 10/11=address-only
//   addr     register address, latched on accept
//   wdata    write data, latched on accept
//   rdata    last read result
//   busy     high from the accept edge until the return to idle
//   done     one-cycle pulse in the first recovery cycle
//   AD       low during the address phase
//   CS       chip select, active-low
//   WR       write / address-latch strobe, active-low
//   RD       read strobe, active-low
//   salient  multiplexed address/data bus, Z when released
module rtc_mux_bus_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned T_SU   = 1,
  parameter int unsigned T_PW   = 4,
  parameter int unsigned T_HD   = 1,
  parameter int unsigned T_GAP  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              AD,
  output logic              CS,
  output logic              WR,
  output logic              RD,
  inout  wire  [DATA_W-1:0] salient
);

  // The counter holds (duration - 1), so it needs room for T_MAX - 1.
  localparam int unsigned T_MAX_0 = (T_SU > T_PW) ? T_SU : T_PW;
  localparam int unsigned T_MAX_1 = (T_HD > T_GAP) ? T_HD : T_GAP;
  localparam int unsigned T_MAX   = (T_MAX_0 > T_MAX_1) ? T_MAX_0 : T_MAX_1;
  localparam int unsigned CNT_W   = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  localparam logic [1:0] OP_WR = 2'b00;
  localparam logic [1:0] OP_RD = 2'b01;
  localparam logic [1:0] OP_AO = 2'b10;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_A_SU = 3'd1;
  localparam logic [2:0] S_A_PW = 3'd2;
  localparam logic [2:0] S_A_HD = 3'd3;
  localparam logic [2:0] S_D_SU = 3'd4;
  localparam logic [2:0] S_D_PW = 3'd5;
  localparam logic [2:0] S_D_HD = 3'd6;
  localparam logic [2:0] S_GAP  = 3'd7;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_d;
  logic [DATA_W-1:0] bus_q, bus_d;
  logic              drv_q, drv_d;
  logic              ad_d, cs_d, wr_d, rd_d, busy_d, done_d;
  logic              last, addr_ph, data_ph, pulse;

  // Bus tristate: driven only from registered enable/data.
  assign salient = drv_q ? bus_q : {DATA_W{1'bz}};

  // Next-state, counter, latch and next-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata;
    last    = (cnt_q == '0);
    if (!last) cnt_d = cnt_q - CNT_W'(1);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_A_SU;
          cnt_d   = CNT_W'(T_SU - 1);
          op_d    = (op == OP_WR || op == OP_RD) ? op : OP_AO;
          addr_d  = addr;
          wdata_d = wdata;
        end
      end
      S_A_SU: if (last) begin state_d = S_A_PW; cnt_d = CNT_W'(T_PW - 1); end
      S_A_PW: if (last) begin state_d = S_A_HD; cnt_d = CNT_W'(T_HD - 1); end
      S_A_HD: begin
        if (last) begin
          if (op_q == OP_AO) begin
            state_d = S_GAP;
            cnt_d   = CNT_W'(T_GAP - 1);
          end else begin
            state_d = S_D_SU;
            cnt_d   = CNT_W'(T_SU - 1);
          end
        end
      end
      S_D_SU: if (last) begin state_d = S_D_PW; cnt_d = CNT_W'(T_PW - 1); end
      S_D_PW: begin
        if (last) begin
          state_d = S_D_HD;
          cnt_d   = CNT_W'(T_HD - 1);
          // Sample the device's data as the read strobe rises.
          if (op_q == OP_RD) rdata_d = salient;
        end
      end
      S_D_HD: if (last) begin state_d = S_GAP; cnt_d = CNT_W'(T_GAP - 1); end
      S_GAP:  if (last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so the flops match the state.
    addr_ph = (state_d == S_A_SU) || (state_d == S_A_PW) || (state_d == S_A_HD);
    data_ph = (state_d == S_D_SU) || (state_d == S_D_PW) || (state_d == S_D_HD);
    pulse   = (state_d == S_A_PW) || (state_d == S_D_PW);
    ad_d    = !addr_ph;
    cs_d    = !pulse;
    wr_d    = !((state_d == S_A_PW) || ((state_d == S_D_PW) && (op_d == OP_WR)));
    rd_d    = !((state_d == S_D_PW) && (op_d == OP_RD));
    drv_d   = addr_ph || (data_ph && (op_d == OP_WR));
    bus_d   = addr_ph ? addr_d : wdata_d;
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_GAP) && (state_q != S_GAP);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_AO;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata   <= '0;
      bus_q   <= '0;
      drv_q   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      AD      <= 1'b1;
      CS      <= 1'b1;
      WR      <= 1'b1;
      RD      <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata   <= rdata_d;
      bus_q   <= bus_d;
      drv_q   <= drv_d;
      busy    <= busy_d;
      done    <= done_d;
      AD      <= ad_d;
      CS      <= cs_d;
      WR      <= wr_d;
      RD      <= rd_d;
    end
  end

endmodule

// File: tb/tb_rtc_mux_bus_ctrl.sv
// tb_rtc_mux_bus_ctrl: directed and random transactions on rtc_mux_bus_ctrl.
// The bench holds the released bus with its own values, so any stray DUT
// drive shows up as a corrupted bus value. Expected strobes come from a
// timeline model built from the phase durations.
module tb_rtc_mux_bus_ctrl;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned T_SU   = 1;
  localparam int unsigned T_PW   = 4;
  localparam int unsigned T_HD   = 1;
  localparam int unsigned T_GAP  = 2;
  localparam int unsigned A_LEN  = T_SU + T_PW + T_HD;

  typedef struct packed {
    logic       ad, cs, wr, rd, busy, done;
    logic [1:0] drv;   // 0 released, 1 address, 2 write data
  } exp_t;

  logic              clk, reset, start;
  logic [1:0]        op;
  logic [DATA_W-1:0] addr, wdata, rdata, tb_val, rdata_m;
  logic              busy, done, AD, CS, WR, RD, tb_en;
  wire  [DATA_W-1:0] salient;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int done_exp = 0;

  assign salient = tb_en ? tb_val : {DATA_W{1'bz}};

  rtc_mux_bus_ctrl #(
    .DATA_W(DATA_W), .T_SU(T_SU), .T_PW(T_PW), .T_HD(T_HD), .T_GAP(T_GAP)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .addr(addr),
    .wdata(wdata), .rdata(rdata), .busy(busy), .done(done), .AD(AD),
    .CS(CS), .WR(WR), .RD(RD), .salient(salient)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Expected bus-side behaviour t cycles after the accept edge.
  function automatic exp_t model(input int t, input logic [1:0] op_v);
    exp_t e;
    bit   data_op;
    int   len, u;
    logic pw;
    data_op = (op_v == 2'b00) || (op_v == 2'b01);
    len     = data_op ? 2 * A_LEN + T_GAP : A_LEN + T_GAP;
    e.ad = 1'b1; e.cs = 1'b1; e.wr = 1'b1; e.rd = 1'b1;
    e.busy = (t < len); e.done = 1'b0; e.drv = 2'd0;
    if (t < A_LEN) begin
      pw   = (t >= T_SU) && (t < T_SU + T_PW);
      e.ad = 1'b0; e.cs = !pw; e.wr = !pw; e.drv = 2'd1;
    end else if (data_op && t < 2 * A_LEN) begin
      u    = t - A_LEN;
      pw   = (u >= T_SU) && (u < T_SU + T_PW);
      e.cs = !pw;
      e.wr = !(pw && op_v == 2'b00);
      e.rd = !(pw && op_v == 2'b01);
      e.drv = (op_v == 2'b00) ? 2'd2 : 2'd0;
    end else if (t < len) begin
      e.done = (t == len - T_GAP);
    end
    return e;
  endfunction

  // Check idle outputs with the bench holding the bus.
  task automatic chk_idle(input string tag);
    chk({tag, "_AD"}, AD, 1);
    chk({tag, "_CS"}, CS, 1);
    chk({tag, "_WR"}, WR, 1);
    chk({tag, "_RD"}, RD, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_bus"}, salient, tb_val);
    chk({tag, "_rdata"}, rdata, rdata_m);
  endtask

  // Start a transaction now, then follow it up to cycle stop_at (or idle).
  // The task returns at the falling edge of the last cycle it followed.
  task automatic do_txn(input logic [1:0] op_v, input logic [DATA_W-1:0] a,
                        input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] rdv,
                        input bit inject, input int stop_at);
    logic [1:0]        opn;
    exp_t              e;
    int                len;
    logic [DATA_W-1:0] exp_bus;
    opn = (op_v == 2'b11) ? 2'b10 : op_v;
    len = (opn == 2'b10) ? A_LEN + T_GAP : 2 * A_LEN + T_GAP;
    start = 1'b1; op = op_v; addr = a; wdata = wd;
    for (int t = 0; t <= len && t <= stop_at; t++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (inject && t == 3) begin
        start = 1'b1; op = 2'($urandom); addr = DATA_W'($urandom); wdata = DATA_W'($urandom);
      end
      e = model(t, opn);
      if (e.drv == 2'd0) begin
        tb_en  = 1'b1;
        tb_val = (opn == 2'b01 && t >= A_LEN && t < 2 * A_LEN) ? rdv : DATA_W'($urandom);
      end else begin
        tb_en = 1'b0;
      end
      if (opn == 2'b01 && t == A_LEN + T_SU + T_PW) rdata_m = rdv;
      exp_bus = (e.drv == 2'd1) ? a : (e.drv == 2'd2) ? wd : tb_val;
      if (e.done) done_exp++;
      @(negedge clk);
      if (done) done_cnt++;
      chk($sformatf("t%0d_AD", t), AD, e.ad);
      chk($sformatf("t%0d_CS", t), CS, e.cs);
      chk($sformatf("t%0d_WR", t), WR, e.wr);
      chk($sformatf("t%0d_RD", t), RD, e.rd);
      chk($sformatf("t%0d_busy", t), busy, e.busy);
      chk($sformatf("t%0d_done", t), done, e.done);
      chk($sformatf("t%0d_bus", t), salient, exp_bus);
      chk($sformatf("t%0d_rdata", t), rdata, rdata_m);
      chk($sformatf("t%0d_wr_rd_excl", t), (WR | RD), 1);
    end
    start = 1'b0;
  endtask

  initial begin
    int dc0;
    reset = 1'b0; start = 1'b0; op = 2'b00; addr = '0; wdata = '0;
    tb_en = 1'b1; tb_val = 8'h5A; rdata_m = '0;

    // Reset held for three edges, then released.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle("rst_hold");
    reset = 1'b1;
    @(negedge clk);
    chk_idle("rst_rel");

    // Directed write, read, address-only.
    do_txn(2'b00, 8'h21, 8'h15, 8'h00, 0, 1000);
    do_txn(2'b01, 8'hF0, 8'h00, 8'hA5, 0, 1000);
    chk("read_rdata", rdata, 8'hA5);
    do_txn(2'b10, 8'h00, 8'h77, 8'h00, 0, 1000);
    do_txn(2'b11, 8'h3C, 8'h99, 8'h00, 0, 1000);

    // Start while busy is ignored; a start on the idle cycle is taken at once.
    dc0 = done_cnt;
    do_txn(2'b00, 8'h81, 8'h42, 8'h00, 1, 1000);
    do_txn(2'b01, 8'h18, 8'h00, DATA_W'($urandom), 0, 1000);
    chk("b2b_done_count", done_cnt - dc0, 2);

    // Reset during the write pulse abandons the transaction silently.
    dc0 = done_cnt;
    do_txn(2'b00, 8'hC3, 8'h6E, 8'h00, 0, A_LEN + T_SU + 1);
    reset = 1'b0;
    tb_en = 1'b1; tb_val = DATA_W'($urandom);
    rdata_m = '0;
    @(negedge clk);
    chk_idle("abort");
    reset = 1'b1;
    @(negedge clk);
    chk_idle("abort_rel");
    chk("abort_no_done", done_cnt - dc0, 0);
    do_txn(2'b01, 8'h55, 8'h00, DATA_W'($urandom), 0, 1000);

    // Random traffic, some with a stray start while busy.
    for (int i = 0; i < 24; i++) begin
      do_txn(2'($urandom), DATA_W'($urandom), DATA_W'($urandom), DATA_W'($urandom),
             bit'($urandom_range(0, 1)), 1000);
      if ($urandom_range(0, 2) == 0) begin
        @(negedge clk);
        chk_idle("rand_idle");
      end
    end
    chk("total_done", done_cnt, done_exp);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
